branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 152 +++++++++++++++
 tb/tb_branch_predictor.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Gshare conditional-branch predictor with an in-order queue of in-flight guesses.
// Latency: pred_taken is combinational (0 cycles); mispredict is registered (1 cycle after resolve).
// Backpressure: pred_ready drops while the in-flight queue is full; same-cycle pops are not credited.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   pred_valid/pred_pc         fetch asks for a prediction for a conditional branch at pred_pc
//   pred_ready/pred_taken      queue has room / combinational taken guess for pred_pc
//   res_valid/res_taken        oldest in-flight branch resolved with the given outcome
//   flush                      external pipeline flush; rewinds speculative history to committed
//   mispredict                 one-cycle pulse: oldest branch was mispredicted
module branch_predictor #(
    parameter int INDEX_W     = 8,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_ready,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic        flush,
    output logic        mispredict
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

    // Only the low INDEX_W-1 bits of the history snapshot are needed: repair
    // shifts the snapshot left by one and appends the actual outcome.
    typedef struct packed {
        logic [INDEX_W-1:0] idx;
        logic               pred;
        logic [INDEX_W-2:0] ghr;
    } qent_t;

    logic [1:0]         cnt_q [ENTRIES];
    qent_t              q_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INDEX_W-1:0] ghr_q, ghr_d;
    logic [INDEX_W-1:0] cghr_q, cghr_d;
    logic               mispredict_q;

    logic [INDEX_W-1:0] pred_idx;
    logic               pred_fire;
    logic               res_fire;
    logic               mis_now;
    logic               push;
    qent_t              head_ent;
    logic [1:0]         cnt_old;
    logic [1:0]         cnt_new;

    // PC bits outside the index window do not participate in the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:INDEX_W+2], pred_pc[1:0]};

    assign pred_idx   = pred_pc[INDEX_W+1:2] ^ ghr_q;
    assign pred_taken = cnt_q[pred_idx][1];
    assign pred_ready = (count_q != FULL);
    assign pred_fire  = pred_valid & pred_ready;
    assign mispredict = mispredict_q;

    assign head_ent = q_q[head_q];
    assign res_fire = res_valid & (count_q != '0);
    assign mis_now  = res_fire & (head_ent.pred != res_taken);

    // Saturating 2-bit counter trained toward the resolved outcome.
    assign cnt_old = cnt_q[head_ent.idx];
    always_comb begin
        cnt_new = cnt_old;
        if (res_taken) begin
            if (cnt_old != 2'b11) cnt_new = cnt_old + 2'b01;
        end else begin
            if (cnt_old != 2'b00) cnt_new = cnt_old - 2'b01;
        end
    end

    assign cghr_d = res_fire ? {cghr_q[INDEX_W-2:0], res_taken} : cghr_q;

    // Flush outranks mispredict repair, which outranks normal push/pop.
    always_comb begin
        ghr_d   = ghr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push    = 1'b0;
        if (flush) begin
            ghr_d   = cghr_d;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (mis_now) begin
            ghr_d   = {head_ent.ghr, res_taken};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            push = pred_fire;
            if (pred_fire) begin
                ghr_d  = {ghr_q[INDEX_W-2:0], pred_taken};
                tail_d = tail_q + PTR_W'(1);
            end
            if (res_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(res_fire);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (res_fire) begin
            // A resolution trains its counter even when a flush lands on the same edge.
            cnt_q[head_ent.idx] <= cnt_new;
        end
    end

    // Queue payload needs no reset: entries are only read while count_q says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_q[tail_q] <= '{idx: pred_idx, pred: pred_taken, ghr: ghr_q[INDEX_W-2:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ghr_q        <= '0;
            cghr_q       <= '0;
            mispredict_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ghr_q        <= ghr_d;
            cghr_q       <= cghr_d;
            mispredict_q <= mis_now & ~flush;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic        pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        flush;
    logic        mispredict;

    branch_predictor #(.INDEX_W(8), .QUEUE_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_pc    (pred_pc),
        .pred_ready (pred_ready),
        .pred_taken (pred_taken),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .flush      (flush),
        .mispredict (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model: table of counter values, two history registers and a
    // queue of outstanding guesses.
    typedef struct {
        int idx;
        bit pred;
        int ghr;
    } ent_t;

    int   m_ctr [256];
    int   m_ghr;
    int   m_cghr;
    ent_t mq [$];

    bit exp_pt, exp_rdy, exp_mis;
    bit obs_pt, obs_rdy, obs_mis;

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) m_ctr[i] = 1;
        m_ghr  = 0;
        m_cghr = 0;
        mq.delete();
        exp_mis = 0;
    endfunction

    function automatic void model_step(bit pv, int pc, bit rv, bit rt, bit fl);
        int   idx;
        bit   mis;
        int   new_cghr;
        ent_t h;
        ent_t e;
        idx      = ((pc >> 2) % 256) ^ m_ghr;
        exp_pt   = (m_ctr[idx] >= 2);
        exp_rdy  = (mq.size() != 4);
        mis      = 0;
        new_cghr = m_cghr;
        h        = '{0, 0, 0};
        if (rv && mq.size() > 0) begin
            h        = mq[0];
            new_cghr = (m_cghr * 2 + int'(rt)) % 256;
            if (rt) m_ctr[h.idx] = (m_ctr[h.idx] == 3) ? 3 : m_ctr[h.idx] + 1;
            else    m_ctr[h.idx] = (m_ctr[h.idx] == 0) ? 0 : m_ctr[h.idx] - 1;
            mis = (h.pred != rt);
        end
        if (fl) begin
            mq.delete();
            m_ghr = new_cghr;
            mis   = 0;
        end else if (mis) begin
            mq.delete();
            m_ghr = (h.ghr * 2 + int'(rt)) % 256;
        end else begin
            if (rv && mq.size() > 0) void'(mq.pop_front());
            if (pv && exp_rdy) begin
                e.idx  = idx;
                e.pred = exp_pt;
                e.ghr  = m_ghr;
                mq.push_back(e);
                m_ghr = (m_ghr * 2 + int'(exp_pt)) % 256;
            end
        end
        m_cghr  = new_cghr;
        exp_mis = mis;
    endfunction

    // Entered at posedge+1; samples combinational outputs before the edge and
    // the registered pulse one time unit after it.
    task automatic cycle(input bit pv, input int pc, input bit rv, input bit rt, input bit fl);
        pred_valid = pv;
        pred_pc    = pc;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
        #1;
        obs_pt  = pred_taken;
        obs_rdy = pred_ready;
        model_step(pv, pc, rv, rt, fl);
        @(posedge clk);
        #1;
        obs_mis    = mispredict;
        pred_valid = 0;
        res_valid  = 0;
        res_taken  = 0;
        flush      = 0;
    endtask

    task automatic do_reset();
        pred_valid = 0;
        pred_pc    = 0;
        res_valid  = 0;
        res_taken  = 0;
        flush      = 0;
        reset      = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    function automatic int pc_for_index(int idx);
        return (((idx ^ m_ghr) % 256) << 2) | ($urandom & 32'hFFFF_FC00);
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (pred_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got=%b want=1", pred_ready);
        end
        n_cmp++;
        if (mispredict !== 1'b0) begin
            n_bad++; $display("FAIL reset_mispredict got=%b want=0", mispredict);
        end
        for (int i = 0; i < 4; i++) begin
            pred_pc = $urandom;
            #1;
            n_cmp++;
            if (pred_taken !== 1'b0) begin
                n_bad++; $display("FAIL reset_pred_taken pc=%h got=%b want=0", pred_pc, pred_taken);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        cycle(1, 32'h100, 0, 0, 0);
        n_cmp++;
        if (obs_pt !== exp_pt) begin
            n_bad++; $display("FAIL basic_pred got=%b want=%b", obs_pt, exp_pt);
        end
        n_cmp++;
        if (int'(dut.count_q) != mq.size()) begin
            n_bad++; $display("FAIL basic_count got=%0d want=%0d", dut.count_q, mq.size());
        end
        cycle(0, 0, 1, 0, 0);
        n_cmp++;
        if (obs_mis !== exp_mis) begin
            n_bad++; $display("FAIL basic_mis got=%b want=%b", obs_mis, exp_mis);
        end
        n_cmp++;
        if (int'(dut.cnt_q[8'h40]) != m_ctr[64]) begin
            n_bad++; $display("FAIL basic_ctr got=%0d want=%0d", dut.cnt_q[8'h40], m_ctr[64]);
        end
        n_cmp++;
        if (int'(dut.ghr_q) != m_ghr || int'(dut.cghr_q) != m_cghr) begin
            n_bad++; $display("FAIL basic_ghr got=%h/%h want=%h/%h", dut.ghr_q, dut.cghr_q, m_ghr, m_cghr);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bit outcome;
            outcome = (i < 5);
            cycle(1, pc_for_index(64), 0, 0, 0);
            n_cmp++;
            if (obs_pt !== exp_pt) begin
                n_bad++; $display("FAIL sat_pred iter=%0d got=%b want=%b", i, obs_pt, exp_pt);
            end
            cycle(0, 0, 1, outcome, 0);
            n_cmp++;
            if (obs_mis !== exp_mis) begin
                n_bad++; $display("FAIL sat_mis iter=%0d got=%b want=%b", i, obs_mis, exp_mis);
            end
            n_cmp++;
            if (int'(dut.cnt_q[8'h40]) != m_ctr[64]) begin
                n_bad++; $display("FAIL sat_ctr iter=%0d got=%0d want=%0d", i, dut.cnt_q[8'h40], m_ctr[64]);
            end
        end
    endtask

    task automatic test_full();
        int ghr_before;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, $urandom, 0, 0, 0);
            n_cmp++;
            if (obs_rdy !== exp_rdy) begin
                n_bad++; $display("FAIL full_fill_ready i=%0d got=%b want=%b", i, obs_rdy, exp_rdy);
            end
        end
        ghr_before = m_ghr;
        cycle(1, $urandom, 0, 0, 0);
        n_cmp++;
        if (obs_rdy !== exp_rdy) begin
            n_bad++; $display("FAIL full_ready got=%b want=%b", obs_rdy, exp_rdy);
        end
        n_cmp++;
        if (int'(dut.ghr_q) != ghr_before || int'(dut.count_q) != mq.size()) begin
            n_bad++; $display("FAIL full_hold ghr=%h count=%0d want=%h/%0d", dut.ghr_q, dut.count_q, ghr_before, mq.size());
        end
        cycle(1, $urandom, 1, mq[0].pred, 0);
        n_cmp++;
        if (obs_rdy !== exp_rdy) begin
            n_bad++; $display("FAIL full_pop_ready got=%b want=%b", obs_rdy, exp_rdy);
        end
        cycle(0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_rdy !== exp_rdy || int'(dut.count_q) != mq.size()) begin
            n_bad++; $display("FAIL full_after ready=%b count=%0d want=%b/%0d", obs_rdy, dut.count_q, exp_rdy, mq.size());
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, $urandom, 0, 0, 0);
        cycle(1, $urandom, 1, 1, 0);
        n_cmp++;
        if (obs_mis !== exp_mis) begin
            n_bad++; $display("FAIL mis_pulse got=%b want=%b", obs_mis, exp_mis);
        end
        n_cmp++;
        if (int'(dut.count_q) != mq.size() || int'(dut.ghr_q) != m_ghr) begin
            n_bad++; $display("FAIL mis_repair count=%0d ghr=%h want=%0d/%h", dut.count_q, dut.ghr_q, mq.size(), m_ghr);
        end
        cycle(0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_mis !== 1'b0) begin
            n_bad++; $display("FAIL mis_single got=%b want=0", obs_mis);
        end
    endtask

    task automatic test_flush();
        int trained_idx;
        do_reset();
        cycle(1, $urandom, 0, 0, 0);
        cycle(1, $urandom, 0, 0, 0);
        trained_idx = mq[0].idx;
        cycle(1, $urandom, 1, mq[0].pred, 1);
        n_cmp++;
        if (obs_mis !== exp_mis) begin
            n_bad++; $display("FAIL flush_mis got=%b want=%b", obs_mis, exp_mis);
        end
        n_cmp++;
        if (int'(dut.count_q) != mq.size() || int'(dut.ghr_q) != m_ghr || int'(dut.cghr_q) != m_cghr) begin
            n_bad++; $display("FAIL flush_state count=%0d ghr=%h cghr=%h want=%0d/%h/%h",
                              dut.count_q, dut.ghr_q, dut.cghr_q, mq.size(), m_ghr, m_cghr);
        end
        n_cmp++;
        if (int'(dut.cnt_q[trained_idx]) != m_ctr[trained_idx]) begin
            n_bad++; $display("FAIL flush_train got=%0d want=%0d", dut.cnt_q[trained_idx], m_ctr[trained_idx]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, $urandom, 0, 0, 0);
        cycle(1, $urandom, 0, 0, 0);
        cycle(0, 0, 1, !mq[0].pred, 0);
        n_cmp++;
        if (obs_mis !== exp_mis) begin
            n_bad++; $display("FAIL rmid_pending got=%b want=%b", obs_mis, exp_mis);
        end
        #2;
        reset = 1;
        model_reset();
        #1;
        n_cmp++;
        if (mispredict !== 1'b0 || pred_ready !== 1'b1 || dut.count_q !== '0) begin
            n_bad++; $display("FAIL rmid_clear mis=%b ready=%b count=%0d want=0/1/0", mispredict, pred_ready, dut.count_q);
        end
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            bit pv, rv, rt, fl;
            int pc;
            pv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 31) == 0);
            pc = $urandom & 32'h0000_00FC;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) rt = mq[0].pred;
            else rt = $urandom_range(0, 1);
            cycle(pv, pc, rv, rt, fl);
            n_cmp++;
            if (obs_pt !== exp_pt || obs_rdy !== exp_rdy) begin
                n_bad++; $display("FAIL rand_comb n=%0d pt=%b rdy=%b want=%b/%b", n, obs_pt, obs_rdy, exp_pt, exp_rdy);
            end
            n_cmp++;
            if (obs_mis !== exp_mis) begin
                n_bad++; $display("FAIL rand_mis n=%0d got=%b want=%b", n, obs_mis, exp_mis);
            end
            n_cmp++;
            if (int'(dut.ghr_q) != m_ghr || int'(dut.count_q) != mq.size()) begin
                n_bad++; $display("FAIL rand_state n=%0d ghr=%h count=%0d want=%h/%0d", n, dut.ghr_q, dut.count_q, m_ghr, mq.size());
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1;
        pred_valid = 0;
        pred_pc = 0;
        res_valid = 0;
        res_taken = 0;
        flush = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_full();
        test_mispredict();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
